// File: rtl/bt656_pkg.sv
// Shared encodings and widths for the BT656 transmitter run-control slice.
package bt656_pkg;

    localparam int STATE_W = 3;
    localparam int FCNT_W  = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_TRIG  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RST   = 3'd4
    } state_e;

    function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bt656_frame_det.sv
// Frame-end qualifier: rising V edge, gated by F when the stream is interlaced.
module bt656_frame_det
    import bt656_pkg::*;
(
    input  logic i_SysClock,
    input  logic i_ResetN,
    input  logic i_V,
    input  logic i_F,
    input  logic i_Mode,
    input  logic i_Enable,
    output logic o_FrameEnd
);

    logic v_q;
    logic v_d;

    always_comb begin
        v_d = i_V;
    end

    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            v_q <= 1'b0;
        end else begin
            v_q <= v_d;
        end
    end

    // In interlaced mode only the second field's V rise closes a frame.
    always_comb begin
        o_FrameEnd = i_Enable & ~v_q & i_V & (~i_Mode | i_F);
    end

endmodule

// File: rtl/bt656_tx_ctrl.sv
// Run-control sequencer for bt656_tx: trigger, frame counting, drain and re-reset.
// Optional frame limit feature enabled by defining BT656_CTRL_FRAME_LIMIT_EN.
module bt656_tx_ctrl
    import bt656_pkg::*;
#(
    parameter int PRESCALE          = 4,
    parameter int TRIG_CYCLES       = 8,
    parameter int RESET_HOLD_CYCLES = 8
) (
    input  logic              i_SysClock,
    input  logic              i_ResetN,
    input  logic              i_Start,
    input  logic              i_Stop,
    input  logic              i_InterlaceMode,
    input  logic              i_FirstField,
    input  logic [15:0]       i_FirstLine,
`ifdef BT656_CTRL_FRAME_LIMIT_EN
    input  logic [15:0]       i_FrameLimit,
`endif
    input  logic              i_TxVsignal,
    input  logic              i_TxFsignal,
    output logic              o_TxResetN,
    output logic              o_TxValid,
    output logic              o_TxInterlaceMode,
    output logic              o_TxFirstField,
    output logic [15:0]       o_TxFirstLine,
    output logic              o_Busy,
    output logic [STATE_W-1:0] o_State,
    output logic [FCNT_W-1:0] o_FrameCount,
    output logic              o_FrameTick,
    output logic              o_Done
);

    // TxValid must span at least two TX pixel-clock periods to be sampled.
    localparam int TRIG_N = (TRIG_CYCLES < 2 * PRESCALE) ? 2 * PRESCALE : TRIG_CYCLES;
    localparam int HOLD_MAX = (TRIG_N > RESET_HOLD_CYCLES) ? TRIG_N : RESET_HOLD_CYCLES;
    localparam int CW = $clog2(HOLD_MAX + 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                mode_q, mode_d;
    logic                field_q, field_d;
    logic [15:0]         line_q, line_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                tick_q, tick_d;
    logic                done_q, done_d;
    logic                txrst_q, txrst_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                frame_end;
    logic                det_en;
    logic                limit_hit;
`ifdef BT656_CTRL_FRAME_LIMIT_EN
    logic [15:0]         limit_q, limit_d;
`endif

    assign det_en = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    bt656_frame_det u_det (
        .i_SysClock (i_SysClock),
        .i_ResetN   (i_ResetN),
        .i_V        (i_TxVsignal),
        .i_F        (i_TxFsignal),
        .i_Mode     (mode_q),
        .i_Enable   (det_en),
        .o_FrameEnd (frame_end)
    );

`ifdef BT656_CTRL_FRAME_LIMIT_EN
    assign limit_hit = (limit_q != '0) && (sat_inc(fcnt_q) == limit_q);
`else
    assign limit_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        mode_d  = mode_q;
        field_d = field_q;
        line_d  = line_q;
        fcnt_d  = fcnt_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
`ifdef BT656_CTRL_FRAME_LIMIT_EN
        limit_d = limit_q;
`endif
        if (frame_end) begin
            fcnt_d = sat_inc(fcnt_q);
            tick_d = 1'b1;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (i_Start && !i_Stop) begin
                    state_d = ST_TRIG;
                    mode_d  = i_InterlaceMode;
                    field_d = i_FirstField;
                    line_d  = i_FirstLine;
                    fcnt_d  = '0;
`ifdef BT656_CTRL_FRAME_LIMIT_EN
                    limit_d = i_FrameLimit;
`endif
                end
            end
            ST_TRIG: begin
                if (i_Stop) begin
                    state_d = ST_RST;
                end else if (cnt_q == CW'(TRIG_N - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (frame_end && (i_Stop || limit_hit)) begin
                    state_d = ST_RST;
                end else if (i_Stop) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (frame_end) begin
                    state_d = ST_RST;
                end
            end
            ST_RST: begin
                if (cnt_q == CW'(RESET_HOLD_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RST;
        endcase
        txrst_d = (state_d == ST_TRIG) || (state_d == ST_RUN) ||
                  (state_d == ST_DRAIN);
        valid_d = (state_d == ST_TRIG);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            field_q <= 1'b0;
            line_q  <= '0;
            fcnt_q  <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            txrst_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef BT656_CTRL_FRAME_LIMIT_EN
            limit_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            field_q <= field_d;
            line_q  <= line_d;
            fcnt_q  <= fcnt_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            txrst_q <= txrst_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
`ifdef BT656_CTRL_FRAME_LIMIT_EN
            limit_q <= limit_d;
`endif
        end
    end

    assign o_TxResetN        = txrst_q;
    assign o_TxValid         = valid_q;
    assign o_TxInterlaceMode = mode_q;
    assign o_TxFirstField    = field_q;
    assign o_TxFirstLine     = line_q;
    assign o_Busy            = busy_q;
    assign o_State           = state_q;
    assign o_FrameCount      = fcnt_q;
    assign o_FrameTick       = tick_q;
    assign o_Done            = done_q;

endmodule

// File: tb/tb_bt656_tx_ctrl.sv
// Directed bench for bt656_tx_ctrl; V/F driven directly to emulate bt656_tx.
module tb_bt656_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, imode, ifield;
    logic [15:0] iline;
    logic [15:0] ilimit;
    logic        vsig, fsig;
    logic        tx_rstn, tx_valid, tx_mode, tx_field;
    logic [15:0] tx_line;
    logic        busy;
    logic [2:0]  state;
    logic [15:0] fcnt;
    logic        ftick, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bt656_tx_ctrl dut (
        .i_SysClock        (clk),
        .i_ResetN          (rst_n),
        .i_Start           (start),
        .i_Stop            (stop),
        .i_InterlaceMode   (imode),
        .i_FirstField      (ifield),
        .i_FirstLine       (iline),
`ifdef BT656_CTRL_FRAME_LIMIT_EN
        .i_FrameLimit      (ilimit),
`endif
        .i_TxVsignal       (vsig),
        .i_TxFsignal       (fsig),
        .o_TxResetN        (tx_rstn),
        .o_TxValid         (tx_valid),
        .o_TxInterlaceMode (tx_mode),
        .o_TxFirstField    (tx_field),
        .o_TxFirstLine     (tx_line),
        .o_Busy            (busy),
        .o_State           (state),
        .o_FrameCount      (fcnt),
        .o_FrameTick       (ftick),
        .o_Done            (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic v_rise(input logic f);
        vsig = 1'b1;
        fsig = f;
        tick(1);
        vsig = 1'b0;
    endtask

    task automatic frame(input logic f);
        v_rise(f);
        tick(2);
    endtask

    task automatic do_start(input logic m, input logic fld, input logic [15:0] ln,
                            input logic [15:0] lim);
        imode  = m;
        ifield = fld;
        iline  = ln;
        ilimit = lim;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 0; stop = 0; imode = 0; ifield = 0;
        iline = '0; ilimit = '0; vsig = 0; fsig = 0;
        tick(2);
        chk("rst_state", state, 0);
        chk("rst_txrstn", tx_rstn, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fcnt", fcnt, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        tick(1);

        // 1: start progressive, TRIG window, masked V edge during TRIG
        do_start(1'b0, 1'b1, 16'h0015, 16'd0);
        chk("t1_state_trig", state, 1);
        chk("t1_txrstn", tx_rstn, 1);
        chk("t1_valid", tx_valid, 1);
        chk("t1_busy", busy, 1);
        chk("t1_line", tx_line, 16'h0015);
        chk("t1_field", tx_field, 1);
        tick(2);
        vsig = 1'b1;
        tick(2);
        vsig = 1'b0;
        tick(3);
        chk("t1_valid_last", tx_valid, 1);
        tick(1);
        chk("t1_valid_low", tx_valid, 0);
        chk("t1_state_run", state, 2);
        chk("t1_trig_masked", fcnt, 0);

        // 2: three frames, stop mid-frame, drain to end of frame 4
        v_rise(1'b0);
        chk("t2_tick", ftick, 1);
        tick(2);
        chk("t2_tick_clr", ftick, 0);
        frame(1'b0);
        frame(1'b0);
        chk("t2_fcnt3", fcnt, 3);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("t2_drain", state, 3);
        chk("t2_drain_rstn", tx_rstn, 1);
        tick(2);
        v_rise(1'b0);
        chk("t2_rst", state, 4);
        chk("t2_rst_rstn", tx_rstn, 0);
        chk("t2_fcnt4", fcnt, 4);
        tick(7);
        chk("t2_rst_hold", state, 4);
        chk("t2_no_done", done, 0);
        tick(1);
        chk("t2_idle", state, 0);
        chk("t2_done", done, 1);
        chk("t2_busy0", busy, 0);
        tick(1);
        chk("t2_done_pulse", done, 0);
        chk("t2_fcnt_keep", fcnt, 4);

        // 3: interlaced, only V rise with F=1 counts
        do_start(1'b1, 1'b0, 16'h0004, 16'd0);
        chk("t3_fcnt_clr", fcnt, 0);
        chk("t3_mode", tx_mode, 1);
        tick(8);
        chk("t3_run", state, 2);
        frame(1'b0);
        chk("t3_f1_nocnt", fcnt, 0);
        v_rise(1'b1);
        chk("t3_f2_tick", ftick, 1);
        chk("t3_f2_cnt", fcnt, 1);
        tick(2);
        frame(1'b0);
        frame(1'b1);
        chk("t3_cnt2", fcnt, 2);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        v_rise(1'b0);
        chk("t3_drain_f1", state, 3);
        tick(2);
        v_rise(1'b1);
        chk("t3_rst", state, 4);
        chk("t3_cnt3", fcnt, 3);
        tick(8);
        chk("t3_done", done, 1);

        // 4: stop during TRIG aborts
        tick(1);
        do_start(1'b0, 1'b0, 16'h0001, 16'd0);
        tick(2);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("t4_rst", state, 4);
        chk("t4_rstn", tx_rstn, 0);
        chk("t4_valid", tx_valid, 0);
        chk("t4_fcnt", fcnt, 0);
        tick(7);
        chk("t4_hold", tx_rstn, 0);
        tick(1);
        chk("t4_done", done, 1);
        chk("t4_idle", state, 0);

        // 5: start+stop in IDLE; start while RUN ignored; stop with frame end
        imode = 1'b0;
        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        chk("t5_stay_idle", state, 0);
        chk("t5_busy", busy, 0);
        do_start(1'b0, 1'b1, 16'h0022, 16'd0);
        tick(8);
        chk("t5_run", state, 2);
        do_start(1'b1, 1'b0, 16'h0099, 16'd0);
        chk("t5_ign_state", state, 2);
        chk("t5_ign_line", tx_line, 16'h0022);
        chk("t5_ign_mode", tx_mode, 0);
        stop = 1'b1;
        v_rise(1'b0);
        stop = 1'b0;
        chk("t5_stop_fe", state, 4);
        chk("t5_stop_fe_cnt", fcnt, 1);
        tick(8);
        chk("t5_done", done, 1);

`ifdef BT656_CTRL_FRAME_LIMIT_EN
        // 6: frame limit 2, then unlimited
        tick(1);
        do_start(1'b0, 1'b0, 16'h0000, 16'd2);
        tick(8);
        frame(1'b0);
        chk("t6_l2_run", state, 2);
        v_rise(1'b0);
        chk("t6_l2_rst", state, 4);
        chk("t6_l2_cnt", fcnt, 2);
        tick(8);
        chk("t6_l2_done", done, 1);
        tick(1);
        do_start(1'b0, 1'b0, 16'h0000, 16'd0);
        tick(8);
        frame(1'b0);
        frame(1'b0);
        frame(1'b0);
        chk("t6_l0_run", state, 2);
        chk("t6_l0_cnt", fcnt, 3);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        v_rise(1'b0);
        chk("t6_l0_rst", state, 4);
        tick(8);
`endif

        // async reset mid-run
        tick(1);
        do_start(1'b0, 1'b0, 16'h0007, 16'd0);
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("ar_state", state, 0);
        chk("ar_rstn", tx_rstn, 0);
        chk("ar_valid", tx_valid, 0);
        chk("ar_line", tx_line, 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
